// File: rtl/lru_snapshot_reader_if.sv
// Valid/ready byte stream carrying snapshot entries from the reader to a sink.
interface lru_snapshot_reader_if #(
    parameter int DATA_W = 8
) ();
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_index;
    logic              out_valid;
    logic              out_ready;
    logic              out_last;

    modport master (
        output out_data,
        output out_index,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_index,
        input  out_valid,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/lru_snapshot_reader.sv
// Snapshots the four LRU buffer outputs on request, streams them MRU->LRU and
// reports whether a lookup key is present in the snapshot (and where).
module lru_snapshot_reader #(
    parameter int DATA_W    = 8,
    parameter bit SKIP_ZERO = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] lookup_key,
    lru_snapshot_reader_if.master strm,
    output logic              busy,
    output logic              done,
    output logic              hit,
    output logic [1:0]        hit_pos
);

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        SEND,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [DATA_W-1:0] snap   [4];
    logic [DATA_W-1:0] in_vec [4];
    logic [1:0]        ptr;
    logic [1:0]        ptr_nxt;
    logic              capture;
    logic [3:0]        in_ok;
    logic [3:0]        snap_ok;
    logic              found_first;
    logic [1:0]        first_idx;
    logic              found_above;
    logic [1:0]        above_idx;
    logic              match_any;
    logic [1:0]        match_pos;

    always_comb begin
        in_vec[0] = in0;
        in_vec[1] = in1;
        in_vec[2] = in2;
        in_vec[3] = in3;
    end

    // An entry is streamable unless zero-skipping is on and it holds the empty value.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            in_ok[k]   = !SKIP_ZERO || (in_vec[k] != '0);
            snap_ok[k] = !SKIP_ZERO || (snap[k] != '0);
        end
    end

    // Descending scans leave the lowest qualifying index in the result.
    always_comb begin
        found_first = 1'b0;
        first_idx   = '0;
        found_above = 1'b0;
        above_idx   = ptr;
        match_any   = 1'b0;
        match_pos   = '0;
        for (int k = 3; k >= 0; k--) begin
            if (in_ok[k]) begin
                found_first = 1'b1;
                first_idx   = 2'(k);
            end
            if (snap_ok[k] && (k > int'(ptr))) begin
                found_above = 1'b1;
                above_idx   = 2'(k);
            end
            if (snap[k] == lookup_key) begin
                match_any = 1'b1;
                match_pos = 2'(k);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // NOTE: every output of this block gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        capture        = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;
        strm.out_valid = 1'b0;
        strm.out_last  = 1'b0;
        strm.out_data  = snap[ptr];
        strm.out_index = ptr;
        case (state)
            IDLE: begin
                if (rd_req) state_nxt = CAPTURE;
            end
            CAPTURE: begin
                busy      = 1'b1;
                capture   = 1'b1;
                ptr_nxt   = first_idx;
                state_nxt = found_first ? SEND : DONE;
            end
            SEND: begin
                busy           = 1'b1;
                strm.out_valid = 1'b1;
                strm.out_last  = !found_above;
                if (strm.out_ready) begin
                    if (!found_above) state_nxt = DONE;
                    else              ptr_nxt   = above_idx;
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: the snapshot is only four registers and must read back as zero
    // after reset, so it is reset explicitly rather than left as uninitialised storage.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr     <= '0;
            hit     <= 1'b0;
            hit_pos <= '0;
            for (int k = 0; k < 4; k++) snap[k] <= '0;
        end else begin
            ptr     <= ptr_nxt;
            hit     <= match_any;
            hit_pos <= match_pos;
            if (capture) begin
                for (int k = 0; k < 4; k++) snap[k] <= in_vec[k];
            end
        end
    end

endmodule

// File: tb/tb_lru_snapshot_reader.sv
// Scoreboard bench: expected beats are queued as requests are issued and
// compared when the sink accepts them; one DUT per SKIP_ZERO setting.
module tb_lru_snapshot_reader;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] idx;
        logic       last;
    } beat_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rd_req0 = 1'b0;
    logic       rd_req1 = 1'b0;
    logic [7:0] in0 = '0, in1 = '0, in2 = '0, in3 = '0;
    logic [7:0] lookup_key = '0;
    logic       busy0, done0, hit0, busy1, done1, hit1;
    logic [1:0] hit_pos0, hit_pos1;

    int    errors = 0;
    int    checks = 0;
    int    beats1 = 0;
    beat_t q0[$];
    beat_t q1[$];

    logic       stall0 = 1'b0;
    logic [7:0] hold_data0 = '0;
    logic [1:0] hold_idx0 = '0;

    lru_snapshot_reader_if #(.DATA_W(8)) s0 ();
    lru_snapshot_reader_if #(.DATA_W(8)) s1 ();

    lru_snapshot_reader #(.DATA_W(8), .SKIP_ZERO(1'b0)) u_dut (
        .clk(clk), .rst(rst), .rd_req(rd_req0),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .lookup_key(lookup_key), .strm(s0),
        .busy(busy0), .done(done0), .hit(hit0), .hit_pos(hit_pos0)
    );

    lru_snapshot_reader #(.DATA_W(8), .SKIP_ZERO(1'b1)) u_dut_sz (
        .clk(clk), .rst(rst), .rd_req(rd_req1),
        .in0(in0), .in1(in1), .in2(in2), .in3(in3),
        .lookup_key(lookup_key), .strm(s1),
        .busy(busy1), .done(done1), .hit(hit1), .hit_pos(hit_pos1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
        in0 = a; in1 = b; in2 = c; in3 = d;
    endtask

    task automatic push4(input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] c, input logic [7:0] d);
        q0.push_back('{data: a, idx: 2'd0, last: 1'b0});
        q0.push_back('{data: b, idx: 2'd1, last: 1'b0});
        q0.push_back('{data: c, idx: 2'd2, last: 1'b0});
        q0.push_back('{data: d, idx: 2'd3, last: 1'b1});
    endtask

    // Sink for the plain DUT: checks hold-during-stall and pops on handshake.
    always @(negedge clk) begin
        beat_t e;
        if (s0.out_valid === 1'b1) begin
            if (stall0) begin
                check("hold_data", 32'(s0.out_data), 32'(hold_data0));
                check("hold_idx", 32'(s0.out_index), 32'(hold_idx0));
            end
            if (s0.out_ready === 1'b1) begin
                if (q0.size() == 0) begin
                    check("extra_beat0", 32'(q0.size()), 1);
                end else begin
                    e = q0.pop_front();
                    check("beat_data", 32'(s0.out_data), 32'(e.data));
                    check("beat_idx", 32'(s0.out_index), 32'(e.idx));
                    check("beat_last", 32'(s0.out_last), 32'(e.last));
                end
            end
            stall0     = (s0.out_ready !== 1'b1);
            hold_data0 = s0.out_data;
            hold_idx0  = s0.out_index;
        end else begin
            stall0 = 1'b0;
        end
    end

    always @(negedge clk) begin
        beat_t e;
        if (s1.out_valid === 1'b1 && s1.out_ready === 1'b1) begin
            beats1++;
            if (q1.size() == 0) begin
                check("extra_beat1", 32'(q1.size()), 1);
            end else begin
                e = q1.pop_front();
                check("sz_beat_data", 32'(s1.out_data), 32'(e.data));
                check("sz_beat_idx", 32'(s1.out_index), 32'(e.idx));
                check("sz_beat_last", 32'(s1.out_last), 32'(e.last));
            end
        end
    end

    // Issues rd_req on the plain DUT and waits (bounded) for the last handshake.
    task automatic run_main(input bit toggle, input bit mid);
        bit seen;
        bit hs_last;
        seen = 1'b0;
        s0.out_ready = 1'b1;
        rd_req0 = 1'b1;
        tick();
        rd_req0 = 1'b0;
        check("capture_busy", 32'(busy0), 1);
        check("capture_valid", 32'(s0.out_valid), 0);
        for (int n = 0; n < 40 && !seen; n++) begin
            if (toggle) s0.out_ready = (n % 2 == 0);
            if (mid && n == 1) begin
                set_in(8'd8, 8'd7, 8'd5, 8'd4);
                rd_req0 = 1'b1;
            end else begin
                rd_req0 = 1'b0;
            end
            hs_last = s0.out_valid & s0.out_ready & s0.out_last;
            tick();
            if (hs_last) begin
                seen = 1'b1;
                check("done_pulse", 32'(done0), 1);
                check("busy_in_done", 32'(busy0), 0);
                check("valid_in_done", 32'(s0.out_valid), 0);
            end
        end
        rd_req0 = 1'b0;
        s0.out_ready = 1'b1;
        check("stream_end_seen", 32'(seen), 1);
        tick();
        check("done_single", 32'(done0), 0);
        check("idle_busy", 32'(busy0), 0);
        check("idle_valid", 32'(s0.out_valid), 0);
        check("q0_drained", 32'(q0.size()), 0);
    endtask

    initial begin
        int b;
        s0.out_ready = 1'b1;
        s1.out_ready = 1'b1;

        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_valid", 32'(s0.out_valid), 0);
        check("rst_busy", 32'(busy0), 0);
        check("rst_done", 32'(done0), 0);
        check("rst_hit", 32'(hit0), 0);
        check("rst_hit_pos", 32'(hit_pos0), 0);
        check("rst_data", 32'(s0.out_data), 0);
        check("rst_index", 32'(s0.out_index), 0);
        check("rst_last", 32'(s0.out_last), 0);
        rst = 1'b0;
        tick();

        // Free-flowing stream
        set_in(8'd4, 8'd5, 8'd1, 8'd2);
        push4(8'd4, 8'd5, 8'd1, 8'd2);
        run_main(1'b0, 1'b0);

        // Back-pressure 1010...
        push4(8'd4, 8'd5, 8'd1, 8'd2);
        run_main(1'b1, 1'b0);

        // Inputs change and a second rd_req arrive mid-stream
        set_in(8'd4, 8'd5, 8'd1, 8'd2);
        push4(8'd4, 8'd5, 8'd1, 8'd2);
        run_main(1'b0, 1'b1);

        // Lookup on snapshot {4,5,3,4}
        set_in(8'd4, 8'd5, 8'd3, 8'd4);
        push4(8'd4, 8'd5, 8'd3, 8'd4);
        run_main(1'b0, 1'b0);
        set_in(8'd9, 8'd9, 8'd9, 8'd9);
        lookup_key = 8'd4;
        tick();
        check("hit_key4", 32'(hit0), 1);
        check("pos_key4", 32'(hit_pos0), 0);
        lookup_key = 8'd3;
        tick();
        check("hit_key3", 32'(hit0), 1);
        check("pos_key3", 32'(hit_pos0), 2);
        lookup_key = 8'd5;
        tick();
        check("pos_key5", 32'(hit_pos0), 1);
        lookup_key = 8'd9;
        tick();
        check("hit_key9", 32'(hit0), 0);
        check("pos_key9", 32'(hit_pos0), 0);

        // SKIP_ZERO: single streamable entry
        set_in(8'd3, 8'd0, 8'd0, 8'd0);
        q1.push_back('{data: 8'd3, idx: 2'd0, last: 1'b1});
        rd_req1 = 1'b1;
        tick();
        rd_req1 = 1'b0;
        check("sz_capture_busy", 32'(busy1), 1);
        tick();
        check("sz_valid", 32'(s1.out_valid), 1);
        check("sz_last", 32'(s1.out_last), 1);
        tick();
        check("sz_done", 32'(done1), 1);
        check("sz_valid_after", 32'(s1.out_valid), 0);
        check("q1_drained", 32'(q1.size()), 0);
        lookup_key = 8'd0;
        tick();
        check("sz_hit_key0", 32'(hit1), 1);
        check("sz_pos_key0", 32'(hit_pos1), 1);

        // SKIP_ZERO: nothing streamable, done two cycles after rd_req
        set_in(8'd0, 8'd0, 8'd0, 8'd0);
        b = beats1;
        rd_req1 = 1'b1;
        tick();
        rd_req1 = 1'b0;
        check("sz_empty_done_early", 32'(done1), 0);
        tick();
        check("sz_empty_done", 32'(done1), 1);
        check("sz_empty_valid", 32'(s1.out_valid), 0);
        tick();
        check("sz_empty_done_off", 32'(done1), 0);
        check("sz_empty_busy", 32'(busy1), 0);
        check("sz_empty_no_beat", 32'(beats1), 32'(b));

        // Reset lands on the second beat's handshake
        lookup_key = 8'd9;
        set_in(8'd4, 8'd5, 8'd1, 8'd2);
        q0.push_back('{data: 8'd4, idx: 2'd0, last: 1'b0});
        q0.push_back('{data: 8'd5, idx: 2'd1, last: 1'b0});
        s0.out_ready = 1'b1;
        rd_req0 = 1'b1;
        tick();
        rd_req0 = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_valid", 32'(s0.out_valid), 0);
        check("midrst_busy", 32'(busy0), 0);
        check("midrst_done", 32'(done0), 0);
        check("midrst_index", 32'(s0.out_index), 0);
        check("midrst_data", 32'(s0.out_data), 0);
        check("midrst_q0", 32'(q0.size()), 0);
        tick();
        check("midrst_idle", 32'(busy0), 0);

        push4(8'd4, 8'd5, 8'd1, 8'd2);
        run_main(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
